ipg_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the 10G PHY's TX inter-packet-gap side channel between several requesters. Each requester offers 56-bit payload words, each carrying 1–7 valid bytes, grouped into multi-word messages. The arbiter locks onto one requester for a whole message and drives a single registered valid/ready stream. The PHY TX path consumes that stream by embedding one word into each idle control block (type 0x1E) it sends.

---
 rtl/ipg_tx_arbiter.sv | 143 ++++++++++++++
 tb/tb_ipg_tx_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipg_tx_arbiter.sv
// Round-robin arbiter sharing the TX inter-packet-gap side channel.
// Locks onto one requester per message and drives a registered stream.
module ipg_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_WORDS = 16,
  parameter int SRC_W     = $clog2(NUM_REQ)
) (
  input  logic                   tx_clk,
  input  logic                   tx_rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*56-1:0]  req_data,
  input  logic [NUM_REQ*3-1:0]   req_len,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic                   ipg_tx_valid,
  input  logic                   ipg_tx_ready,
  output logic [55:0]            ipg_tx_data,
  output logic [2:0]             ipg_tx_len,
  output logic [SRC_W-1:0]       ipg_tx_src,
  output logic                   ipg_tx_last,
  output logic                   grant_active,
  output logic                   overrun
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  localparam logic [7:0] LIMIT = 8'(MAX_WORDS - 1);

  state_t           state_q, state_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic [SRC_W-1:0] pick, next_ptr;
  logic [7:0]       word_cnt_q, word_cnt_d;
  logic             any_valid;
  logic             load;
  logic             at_limit;
  logic             last_eff;
  logic             sel_valid;
  logic             sel_last;
  logic [55:0]      sel_data;
  logic [2:0]       sel_len;
  int               idx;

  // Lowest circular offset from ptr wins, so scan offsets downward.
  always_comb begin
    pick      = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        pick      = SRC_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

  assign sel_valid = req_valid[grant_q];
  assign sel_last  = req_last[grant_q];
  assign sel_data  = req_data[56*grant_q +: 56];
  assign sel_len   = req_len[3*grant_q +: 3];

  assign load     = (state_q == LOCKED) && sel_valid &&
                    (!ipg_tx_valid || ipg_tx_ready);
  assign at_limit = (word_cnt_q == LIMIT);
  assign last_eff = sel_last || at_limit;

  assign next_ptr = (grant_q == SRC_W'(NUM_REQ - 1)) ?
                    '0 : grant_q + SRC_W'(1);

  assign grant_active = (state_q == LOCKED);

  always_comb begin
    req_ready          = '0;
    req_ready[grant_q] = load;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    word_cnt_d = word_cnt_q;
    unique case (state_q)
      IDLE: begin
        word_cnt_d = '0;
        if (any_valid) begin
          grant_d = pick;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (load) begin
          word_cnt_d = word_cnt_q + 8'd1;
          if (last_eff) begin
            state_d = IDLE;
            ptr_d   = next_ptr;
          end
        end
      end
    endcase
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      ipg_tx_valid <= 1'b0;
      ipg_tx_data  <= '0;
      ipg_tx_len   <= '0;
      ipg_tx_src   <= '0;
      ipg_tx_last  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= load && at_limit && !sel_last;
      if (load) begin
        ipg_tx_valid <= 1'b1;
        ipg_tx_data  <= sel_data;
        ipg_tx_len   <= sel_len;
        ipg_tx_src   <= grant_q;
        ipg_tx_last  <= last_eff;
      end else if (ipg_tx_ready) begin
        ipg_tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ipg_tx_arbiter.sv
// Bench for ipg_tx_arbiter: per-requester word queues, a message-level
// reference model compared every cycle, plus directed literal checks.
module tb_ipg_tx_arbiter;

  localparam int N    = 4;
  localparam int MAXW = 4;
  localparam int SW   = 2;

  logic              tx_clk = 1'b0;
  logic              tx_rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*56-1:0]   req_data = '0;
  logic [N*3-1:0]    req_len = '0;
  logic [N-1:0]      req_last = '0;
  logic              ipg_tx_valid;
  logic              ipg_tx_ready = 1'b0;
  logic [55:0]       ipg_tx_data;
  logic [2:0]        ipg_tx_len;
  logic [SW-1:0]     ipg_tx_src;
  logic              ipg_tx_last;
  logic              grant_active;
  logic              overrun;

  ipg_tx_arbiter #(.NUM_REQ(N), .MAX_WORDS(MAXW)) dut (
    .tx_clk       (tx_clk),
    .tx_rst       (tx_rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .req_len      (req_len),
    .req_last     (req_last),
    .ipg_tx_valid (ipg_tx_valid),
    .ipg_tx_ready (ipg_tx_ready),
    .ipg_tx_data  (ipg_tx_data),
    .ipg_tx_len   (ipg_tx_len),
    .ipg_tx_src   (ipg_tx_src),
    .ipg_tx_last  (ipg_tx_last),
    .grant_active (grant_active),
    .overrun      (overrun)
  );

  always #5 tx_clk = ~tx_clk;

  typedef struct packed {
    logic        last;
    logic [2:0]  len;
    logic [55:0] data;
  } word_t;

  typedef struct {
    int          cyc;
    int          src;
    int          len;
    bit          last;
    logic [55:0] data;
  } xfer_t;

  word_t  q[N][$];
  xfer_t  log_q[$];
  int     ovr_q[$];

  logic [N-1:0] gate = '0;
  logic [N-1:0] cur_vld = '0;
  bit           rdy_in = 1'b0;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // Reference model: who owns the channel, words sent so far in this
  // message, where the next search starts, and the expected output word.
  bit          m_locked;
  int          m_owner;
  int          m_cnt;
  int          m_ptr;
  bit          m_v;
  logic [55:0] m_data;
  logic [2:0]  m_len;
  int          m_src;
  bit          m_last;
  bit          m_ovr;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  function automatic word_t mk(input logic [55:0] d, input int l,
                               input bit last);
    word_t w;
    w.data = d;
    w.len  = 3'(l);
    w.last = last;
    return w;
  endfunction

  task automatic add_msg(input int r, input int nw);
    for (int j = 0; j < nw; j++)
      q[r].push_back(mk(56'({$urandom(), $urandom()}),
                        $urandom_range(1, 7), j == nw - 1));
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
    m_v = 0; m_data = '0; m_len = '0; m_src = 0;
    m_last = 0; m_ovr = 0;
  endtask

  function automatic bit m_load();
    return m_locked && cur_vld[m_owner] && (!m_v || rdy_in);
  endfunction

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      cur_vld[i] = gate[i] && (q[i].size() > 0);
      req_valid[i] = cur_vld[i];
      if (cur_vld[i]) begin
        req_data[56*i +: 56] = q[i][0].data;
        req_len[3*i +: 3]    = q[i][0].len;
        req_last[i]          = q[i][0].last;
      end else begin
        req_data[56*i +: 56] = '0;
        req_len[3*i +: 3]    = '0;
        req_last[i]          = 1'b0;
      end
    end
    ipg_tx_ready = rdy_in;
  endtask

  task automatic model_step();
    bit    ld;
    bit    was_locked;
    bit    found;
    bit    new_ovr;
    int    r;
    word_t w;
    ld         = m_load();
    was_locked = m_locked;
    new_ovr    = 0;
    if (ld) begin
      w       = q[m_owner].pop_front();
      m_v     = 1;
      m_data  = w.data;
      m_len   = w.len;
      m_src   = m_owner;
      m_last  = w.last || (m_cnt == MAXW - 1);
      new_ovr = !w.last && (m_cnt == MAXW - 1);
      m_cnt++;
      if (m_last) begin
        m_locked = 0;
        m_ptr    = (m_owner + 1) % N;
      end
    end else if (rdy_in) begin
      m_v = 0;
    end
    if (!was_locked && cur_vld != '0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        r = (m_ptr + k) % N;
        if (!found && cur_vld[r]) begin
          found   = 1;
          m_owner = r;
        end
      end
      m_locked = 1;
      m_cnt    = 0;
    end
    m_ovr = new_ovr;
  endtask

  task automatic cycle();
    logic [N-1:0] e_rdy;
    @(negedge tx_clk);
    cyc++;
    chk("tx_valid", ipg_tx_valid, m_v);
    if (m_v) begin
      chk("tx_data", ipg_tx_data, m_data);
      chk("tx_len", ipg_tx_len, m_len);
      chk("tx_src", ipg_tx_src, m_src);
      chk("tx_last", ipg_tx_last, m_last);
    end
    chk("overrun", overrun, m_ovr);
    chk("grant_active", grant_active, m_locked);
    if (overrun) ovr_q.push_back(cyc);
    apply_inputs();
    #1;
    e_rdy = '0;
    if (m_load()) e_rdy[m_owner] = 1'b1;
    chk("req_ready", req_ready, e_rdy);
    if (ipg_tx_valid && ipg_tx_ready)
      log_q.push_back('{cyc, int'(ipg_tx_src), int'(ipg_tx_len),
                        ipg_tx_last, ipg_tx_data});
    model_step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_valid"}, ipg_tx_valid, 0);
    chk({tag, "_data"}, ipg_tx_data, 0);
    chk({tag, "_len"}, ipg_tx_len, 0);
    chk({tag, "_src"}, ipg_tx_src, 0);
    chk({tag, "_last"}, ipg_tx_last, 0);
    chk({tag, "_grant"}, grant_active, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  task automatic do_reset();
    tx_rst = 1'b1;
    gate   = '0;
    rdy_in = 0;
    for (int i = 0; i < N; i++) q[i].delete();
    apply_inputs();
    model_reset();
    repeat (2) @(negedge tx_clk);
    #1;
    chk_zero("reset");
    tx_rst = 1'b0;
    log_q.delete();
    ovr_q.delete();
  endtask

  task automatic wait_valid(input string name);
    int t;
    t = 0;
    while (!ipg_tx_valid && t < 10) begin
      cycle();
      t++;
    end
    chk({name, "_valid_timeout"}, ipg_tx_valid, 1);
  endtask

  int rr_exp[6]   = '{0, 1, 2, 3, 0, 1};
  int cut_src[7]  = '{1, 1, 1, 1, 3, 1, 1};
  bit cut_last[7] = '{0, 0, 0, 1, 1, 0, 1};
  logic [55:0] bp_data[3] = '{56'hAABBCCDDEEFF11, 56'h22, 56'h33};
  int n0;

  initial begin
    model_reset();
    do_reset();

    // single message from requester 2
    q[2].push_back(mk(56'h1, 7, 0));
    q[2].push_back(mk(56'h2, 7, 0));
    q[2].push_back(mk(56'h3, 3, 1));
    rdy_in = 1;
    gate   = 4'b0100;
    n0     = cyc + 1;
    repeat (8) cycle();
    chk("single_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("single_lat", log_q[0].cyc, n0 + 2);
      for (int j = 0; j < 3; j++) begin
        chk("single_src", log_q[j].src, 2);
        chk("single_cyc", log_q[j].cyc, n0 + 2 + j);
        chk("single_last", log_q[j].last, j == 2);
      end
      chk("single_len0", log_q[0].len, 7);
      chk("single_len1", log_q[1].len, 7);
      chk("single_len2", log_q[2].len, 3);
    end

    // round robin with 1-word messages
    do_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 4; k++)
        q[i].push_back(mk(56'(i * 16 + k), 1 + k, 1));
    rdy_in = 1;
    gate   = '1;
    repeat (16) cycle();
    chk("rr_count_ok", log_q.size() >= 6, 1);
    if (log_q.size() >= 6)
      for (int j = 0; j < 6; j++) begin
        chk("rr_src", log_q[j].src, rr_exp[j]);
        if (j > 0) chk("rr_gap", log_q[j].cyc - log_q[j-1].cyc, 2);
      end

    // backpressure
    do_reset();
    q[1].push_back(mk(bp_data[0], 7, 0));
    q[1].push_back(mk(bp_data[1], 5, 0));
    q[1].push_back(mk(bp_data[2], 2, 1));
    gate   = 4'b0010;
    rdy_in = 0;
    wait_valid("bp");
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_data", ipg_tx_data, 56'hAABBCCDDEEFF11);
      chk("bp_ready", req_ready, 0);
    end
    rdy_in = 1;
    repeat (8) cycle();
    chk("bp_count", log_q.size(), 3);
    if (log_q.size() == 3)
      for (int j = 0; j < 3; j++) begin
        chk("bp_word", log_q[j].data, bp_data[j]);
        chk("bp_last", log_q[j].last, j == 2);
      end

    // forced cut at MAX_WORDS, then rotation to requester 3
    do_reset();
    for (int j = 0; j < 6; j++)
      q[1].push_back(mk(56'(256 + j), (j % 7) + 1, j == 5));
    q[3].push_back(mk(56'h300, 4, 1));
    gate   = 4'b1010;
    rdy_in = 1;
    repeat (20) cycle();
    chk("cut_count", log_q.size(), 7);
    if (log_q.size() == 7) begin
      for (int j = 0; j < 7; j++) begin
        chk("cut_src", log_q[j].src, cut_src[j]);
        chk("cut_last", log_q[j].last, cut_last[j]);
      end
      chk("cut_ovr_count", ovr_q.size(), 1);
      if (ovr_q.size() == 1) chk("cut_ovr_cyc", ovr_q[0], log_q[3].cyc);
    end

    // requester 0 stalls mid-message while 3 waits
    do_reset();
    q[0].push_back(mk(56'hA0, 7, 0));
    q[0].push_back(mk(56'hA1, 7, 0));
    q[0].push_back(mk(56'hA2, 7, 1));
    q[3].push_back(mk(56'hD0, 6, 1));
    gate   = 4'b1001;
    rdy_in = 1;
    for (int t = 0; t < 10 && q[0].size() != 2; t++) cycle();
    chk("stall_start", q[0].size(), 2);
    gate[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("stall_grant", grant_active, 1);
      chk("stall_rdy3", req_ready[3], 0);
    end
    gate[0] = 1'b1;
    repeat (12) cycle();
    chk("stall_count", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("stall_src0", log_q[0].src, 0);
      chk("stall_src1", log_q[1].src, 0);
      chk("stall_src2", log_q[2].src, 0);
      chk("stall_src3", log_q[3].src, 3);
      chk("stall_last2", log_q[2].last, 1);
    end

    // reset mid-message, search restarts from requester 0
    do_reset();
    q[2].push_back(mk(56'hE0, 7, 0));
    q[2].push_back(mk(56'hE1, 7, 1));
    gate   = 4'b0100;
    rdy_in = 1;
    repeat (8) cycle();
    for (int j = 0; j < 3; j++) q[2].push_back(mk(56'(240 + j), 3, j == 2));
    rdy_in = 0;
    wait_valid("mid");
    #2;
    tx_rst = 1'b1;
    #1;
    chk_zero("async");
    do_reset();
    q[1].push_back(mk(56'hB1, 1, 1));
    q[3].push_back(mk(56'hB3, 1, 1));
    gate   = 4'b1010;
    rdy_in = 1;
    repeat (10) cycle();
    chk("post_rst_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("post_rst_src", log_q[0].src, 1);
      chk("post_rst_data", log_q[0].data, 56'hB1);
    end

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (q[i].size() < 2) add_msg(i, $urandom_range(1, 7));
        gate[i] = ($urandom_range(0, 9) < 8);
      end
      rdy_in = ($urandom_range(0, 9) < 7);
      cycle();
    end
    chk("rand_ovr_seen", ovr_q.size() > 0, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
